// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and constants for the I/D memory fill arbiter.
// Package name is mem_arb_pkg; imported by the interface, arb_pick and the top.
package mem_arb_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LAT         = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  // Words are 2 bytes, so a block spans 2*WORDS_PER_BLOCK byte addresses.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Bundle of cache-side request/grant/fill signals and the main-memory port.
// A requester raises req and holds it (with stable addr/we/wdata) until its done pulse.
interface mem_fill_arbiter_if;
  import mem_arb_pkg::*;

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_grant;
  logic                  i_done;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_grant;
  logic                  d_done;
  logic                  fill_valid;
  logic [DATA_W-1:0]     fill_data;
  logic [WORD_IDX_W-1:0] fill_idx;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_grant, i_done, d_grant, d_done, fill_valid, fill_data, fill_idx,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_grant, i_done, d_grant, d_done, fill_valid, fill_data, fill_idx,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_fill_arbiter_arb_pick.sv
// Combinational 2-way requester select. Ties go to D unless ARB_RR_EN is defined,
// in which case a tie goes to the side not granted last (rr_last_i).
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
`ifdef ARB_RR_EN
  input  req_e rr_last_i,
`endif
  output logic valid_o,
  output req_e pick_o
);

  always_comb begin
    valid_o = i_req_i | d_req_i;
    pick_o  = REQ_I;
    if (d_req_i && !i_req_i) begin
      pick_o = REQ_D;
    end else if (d_req_i && i_req_i) begin
`ifdef ARB_RR_EN
      pick_o = (rr_last_i == REQ_I) ? REQ_D : REQ_I;
`else
      pick_o = REQ_D;
`endif
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined memory between I-cache and D-cache: block fills and posted writes.
// Optional ARB_RR_EN: round-robin tie-break instead of fixed D priority.
module mem_fill_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_fill_arbiter_if.master bus,
  output state_e             dbg_state_o
);

  state_e                state_q;
  req_e                  owner_q;
  logic [WORD_IDX_W-1:0] issue_cnt_q;
  logic [WORD_IDX_W-1:0] recv_cnt_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  i_grant_q;
  logic                  d_grant_q;
  logic                  mem_en_q;
  logic                  mem_wr_q;
`ifdef ARB_RR_EN
  req_e                  rr_q;
`endif

  logic                  pick_valid;
  req_e                  pick_side;
  logic [ADDR_W-1:0]     base_d;
  logic                  in_fill;
  logic                  fill_valid;
  logic                  last_word;

  arb_pick u_pick (
    .i_req_i   (bus.i_req),
    .d_req_i   (bus.d_req),
`ifdef ARB_RR_EN
    .rr_last_i (rr_q),
`endif
    .valid_o   (pick_valid),
    .pick_o    (pick_side)
  );

  // Returned words are only accepted while a fill owns the memory; anything else is stale.
  assign in_fill    = (state_q == ISSUE) || (state_q == DRAIN);
  assign fill_valid = in_fill & bus.mem_rvalid;
  assign last_word  = fill_valid && (recv_cnt_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
  assign base_d     = block_base((pick_side == REQ_D) ? bus.d_addr : bus.i_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= REQ_I;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_grant_q   <= 1'b0;
      d_grant_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
`ifdef ARB_RR_EN
      rr_q        <= REQ_I;
`endif
    end else begin
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      if (fill_valid) begin
        recv_cnt_q <= recv_cnt_q + WORD_IDX_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_side;
`ifdef ARB_RR_EN
            rr_q    <= pick_side;
`endif
            if (pick_side == REQ_D) begin
              d_grant_q <= 1'b1;
            end else begin
              i_grant_q <= 1'b1;
            end
            // Writes go out in the grant cycle itself; fills start issuing one cycle later.
            if (pick_side == REQ_D && bus.d_we) begin
              state_q     <= WRITE;
              mem_en_q    <= 1'b1;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {bus.d_addr[ADDR_W-1:1], 1'b0};
              mem_wdata_q <= bus.d_wdata;
            end else begin
              state_q     <= ISSUE;
              base_q      <= base_d;
              issue_cnt_q <= '0;
              recv_cnt_q  <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en_q    <= 1'b1;
          mem_addr_q  <= base_q + ADDR_W'({issue_cnt_q, 1'b0});
          issue_cnt_q <= issue_cnt_q + WORD_IDX_W'(1);
          if (issue_cnt_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_word) begin
            state_q   <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
          end
        end
        WRITE: begin
          state_q   <= IDLE;
          d_grant_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_grant    = i_grant_q;
  assign bus.d_grant    = d_grant_q;
  assign bus.i_done     = last_word && (owner_q == REQ_I);
  assign bus.d_done     = (last_word && (owner_q == REQ_D)) || (state_q == WRITE);
  assign bus.fill_valid = fill_valid;
  assign bus.fill_data  = fill_valid ? bus.mem_rdata : '0;
  assign bus.fill_idx   = recv_cnt_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed-plus-random bench for mem_fill_arbiter with a latency-accurate memory model.
module tb_mem_fill_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT_TOT = WORDS_PER_BLOCK + MEM_LAT;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_fill_arbiter_if bus();
  state_e dbg_state;

  mem_fill_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  bit last_d = 1'b0;

  // memory contents: a fixed function of the byte address
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  // memory model: read issued in cycle c returns in cycle c+MEM_LAT; not reset by rst
  logic [MEM_LAT-1:0] rv_pipe = '0;
  logic [ADDR_W-1:0]  ra_pipe [MEM_LAT];
  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
    ra_pipe[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) ra_pipe[i] <= ra_pipe[i-1];
  end
  assign bus.mem_rvalid = rv_pipe[MEM_LAT-1];
  assign bus.mem_rdata  = rv_pipe[MEM_LAT-1] ? mem_word(ra_pipe[MEM_LAT-1]) : '0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tie winner from the arbitration rules
  function automatic bit model_pick_d(input bit i, input bit d);
    if (i && d) begin
`ifdef ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_i_grant"}, 32'(bus.i_grant), 32'd0);
    chk({tag, "_d_grant"}, 32'(bus.d_grant), 32'd0);
    chk({tag, "_i_done"}, 32'(bus.i_done), 32'd0);
    chk({tag, "_d_done"}, 32'(bus.d_done), 32'd0);
    chk({tag, "_fill_valid"}, 32'(bus.fill_valid), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b0;
  endtask

  // called at a negedge where the DUT is idle and the request was just raised
  task automatic wait_grant(input bit exp_d, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_grant || bus.d_grant) && n < 20);
    chk({tag, "_grant_latency"}, 32'(n), 32'd1);
    chk({tag, "_grant_d"}, 32'(bus.d_grant), 32'(exp_d));
    chk({tag, "_grant_i"}, 32'(bus.i_grant), 32'(!exp_d));
    last_d = exp_d;
  endtask

  // checks offsets 0..LAT_TOT of a fill (offset 0 = first grant cycle), then the idle cycle
  task automatic run_fill(input bit side_d, input logic [ADDR_W-1:0] addr,
                          input int drop_at, input bit drop_end);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    bit exp_en;
    bit exp_fv;
    base = addr & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    for (int k = 0; k <= LAT_TOT; k++) begin
      exp_en = (k >= 1) && (k <= WORDS_PER_BLOCK);
      exp_fv = (k > MEM_LAT);
      chk($sformatf("fill_k%0d_own_grant", k), 32'(side_d ? bus.d_grant : bus.i_grant), 32'd1);
      chk($sformatf("fill_k%0d_oth_grant", k), 32'(side_d ? bus.i_grant : bus.d_grant), 32'd0);
      chk($sformatf("fill_k%0d_mem_en", k), 32'(bus.mem_en), 32'(exp_en));
      chk($sformatf("fill_k%0d_mem_wr", k), 32'(bus.mem_wr), 32'd0);
      if (exp_en) begin
        a = base + ADDR_W'(2 * (k - 1));
        chk($sformatf("fill_k%0d_mem_addr", k), 32'(bus.mem_addr), 32'(a));
      end
      chk($sformatf("fill_k%0d_fill_valid", k), 32'(bus.fill_valid), 32'(exp_fv));
      if (exp_fv) begin
        a = base + ADDR_W'(2 * (k - MEM_LAT - 1));
        chk($sformatf("fill_k%0d_fill_idx", k), 32'(bus.fill_idx), 32'(k - MEM_LAT - 1));
        chk($sformatf("fill_k%0d_fill_data", k), 32'(bus.fill_data), 32'(mem_word(a)));
      end
      chk($sformatf("fill_k%0d_own_done", k), 32'(side_d ? bus.d_done : bus.i_done),
          32'(k == LAT_TOT));
      chk($sformatf("fill_k%0d_oth_done", k), 32'(side_d ? bus.i_done : bus.d_done), 32'd0);
      if (k == drop_at || (k == LAT_TOT && drop_end)) begin
        if (side_d) bus.d_req = 1'b0;
        else        bus.i_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("fill_end_i_grant", 32'(bus.i_grant), 32'd0);
    chk("fill_end_d_grant", 32'(bus.d_grant), 32'd0);
    chk("fill_end_mem_en", 32'(bus.mem_en), 32'd0);
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    logic [ADDR_W-1:0] wa;
    wa = addr & ~ADDR_W'(1);
    chk("wr_mem_en", 32'(bus.mem_en), 32'd1);
    chk("wr_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'(wa));
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'(data));
    chk("wr_d_done", 32'(bus.d_done), 32'd1);
    chk("wr_i_done", 32'(bus.i_done), 32'd0);
    chk("wr_fill_valid", 32'(bus.fill_valid), 32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk_quiet("wr_after");
  endtask

  logic [ADDR_W-1:0] ia, da, ra;
  logic [DATA_W-1:0] rd;
  bit w1, w2, w3, rside;
  int seen;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("reset_fill_data", 32'(bus.fill_data), 32'd0);
    chk("reset_fill_idx", 32'(bus.fill_idx), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // I fill alone
    bus.i_addr = 16'h1236; bus.i_req = 1'b1;
    wait_grant(model_pick_d(1'b1, 1'b0), "ifill");
    run_fill(1'b0, 16'h1236, -1, 1'b1);

    // D single-word write
    bus.d_addr = 16'h4003; bus.d_wdata = 16'hBEEF; bus.d_we = 1'b1; bus.d_req = 1'b1;
    wait_grant(model_pick_d(1'b0, 1'b1), "dwr");
    run_write(16'h4003, 16'hBEEF);

    // simultaneous fill requests; the first winner immediately requests again
    do_reset();
    ia = 16'($urandom); da = 16'($urandom);
    bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    w1 = model_pick_d(1'b1, 1'b1);
    wait_grant(w1, "tie1");
    run_fill(w1, w1 ? da : ia, -1, 1'b0);
    if (w1) begin da = 16'($urandom); bus.d_addr = da; end
    else    begin ia = 16'($urandom); bus.i_addr = ia; end
    w2 = model_pick_d(1'b1, 1'b1);
    wait_grant(w2, "tie2");
    run_fill(w2, w2 ? da : ia, -1, 1'b1);
    w3 = model_pick_d(w2, !w2);
    wait_grant(w3, "tie3");
    run_fill(w3, w3 ? da : ia, -1, 1'b1);

    // top-of-memory block, request dropped mid-fill
    ra = 16'hFFF0 | 16'($urandom_range(0, 15));
    bus.i_addr = ra; bus.i_req = 1'b1;
    wait_grant(model_pick_d(1'b1, 1'b0), "top");
    run_fill(1'b0, ra, 3, 1'b1);

    // reset in the middle of a fill; late read data must be ignored
    ra = 16'($urandom);
    bus.i_addr = ra; bus.i_req = 1'b1;
    wait_grant(model_pick_d(1'b1, 1'b0), "rstfill");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b0;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (bus.mem_rvalid) seen++;
      chk_quiet($sformatf("stale%0d", j));
      @(negedge clk);
    end
    chk("stale_reads_present", 32'(seen > 0), 32'd1);

    // random single-requester traffic
    for (int r = 0; r < 6; r++) begin
      rside = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rd = 16'($urandom);
      if (rside && $urandom_range(0, 1) == 1) begin
        bus.d_addr = ra; bus.d_wdata = rd; bus.d_we = 1'b1; bus.d_req = 1'b1;
        wait_grant(model_pick_d(1'b0, 1'b1), $sformatf("rnd%0d_wr", r));
        run_write(ra, rd);
      end else if (rside) begin
        bus.d_addr = ra; bus.d_we = 1'b0; bus.d_req = 1'b1;
        wait_grant(model_pick_d(1'b0, 1'b1), $sformatf("rnd%0d_dfill", r));
        run_fill(1'b1, ra, -1, 1'b1);
      end else begin
        bus.i_addr = ra; bus.i_req = 1'b1;
        wait_grant(model_pick_d(1'b1, 1'b0), $sformatf("rnd%0d_ifill", r));
        run_fill(1'b0, ra, -1, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
